// File: rtl/npu_param_loader.sv
// npu_param_loader: deserialises a valid/ready word stream into the packed NPU parameter buses.
// Optional macro NPU_PARAM_CHECKSUM_EN appends a mod-2^DATA_WIDTH sum word to every frame.
module npu_param_loader #(
   parameter int unsigned IN_N       = 2,
   parameter int unsigned HIDDEN_N   = 2,
   parameter int unsigned OUT_N      = 2,
   parameter int unsigned DATA_WIDTH = 8,
   localparam int unsigned W1    = HIDDEN_N * IN_N,
   localparam int unsigned B1    = HIDDEN_N,
   localparam int unsigned W2    = OUT_N * HIDDEN_N,
   localparam int unsigned B2    = OUT_N,
   localparam int unsigned TOTAL = W1 + B1 + W2 + B2,
   localparam int unsigned CW    = $clog2(TOTAL + 2)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH-1:0]      s_data,
   input  logic                       s_last,
   output logic [W1*DATA_WIDTH-1:0]   weights1,
   output logic [B1*DATA_WIDTH-1:0]   biases1,
   output logic [W2*DATA_WIDTH-1:0]   weights2,
   output logic [B2*DATA_WIDTH-1:0]   biases2,
   output logic                       params_valid,
   output logic                       busy,
   output logic                       err,
   output logic [1:0]                 err_code,
   output logic [CW-1:0]              word_cnt
);

`ifdef NPU_PARAM_CHECKSUM_EN
   localparam int unsigned LAST = TOTAL;
`else
   localparam int unsigned LAST = TOTAL - 1;
`endif

   localparam logic [CW-1:0] LastIdx  = CW'(LAST);
   localparam logic [CW-1:0] TotalIdx = CW'(TOTAL);

   typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

   state_e                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [TOTAL*DATA_WIDTH-1:0]  params_q, params_d;
   logic [1:0]                   code_q, code_d;
   logic                         ready_q;
   logic                         accept;

   // load_start wins over a beat presented in the same cycle
   assign accept = s_valid & ready_q & ~load_start;

`ifdef NPU_PARAM_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (load_start) begin
         sum_d = '0;
      end else if (accept && (cnt_q < TotalIdx)) begin
         sum_d = sum_q + s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      params_d = params_q;
      code_d   = code_q;
      if (load_start) begin
         state_d = StLoad;
         cnt_d   = '0;
         code_d  = 2'd0;
      end else if (accept) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q < TotalIdx) begin
            params_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = s_data;
         end
         if (s_last && (cnt_q != LastIdx)) begin
            state_d = StErr;
            code_d  = 2'd1;
         end else if (!s_last && (cnt_q == LastIdx)) begin
            state_d = StErr;
            code_d  = 2'd2;
         end else if (s_last) begin
`ifdef NPU_PARAM_CHECKSUM_EN
            if (s_data != sum_q) begin
               state_d = StErr;
               code_d  = 2'd3;
            end else begin
               state_d = StDone;
            end
`else
            state_d = StDone;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         params_q <= '0;
         code_q   <= 2'd0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         params_q <= params_d;
         code_q   <= code_d;
         ready_q  <= (state_d == StLoad);
      end
   end

   assign s_ready      = ready_q;
   assign busy         = (state_q == StLoad);
   assign params_valid = (state_q == StDone);
   assign err          = (state_q == StErr);
   assign err_code     = code_q;
   assign word_cnt     = cnt_q;

   assign weights1 = params_q[0 +: W1*DATA_WIDTH];
   assign biases1  = params_q[W1*DATA_WIDTH +: B1*DATA_WIDTH];
   assign weights2 = params_q[(W1+B1)*DATA_WIDTH +: W2*DATA_WIDTH];
   assign biases2  = params_q[(W1+B1+W2)*DATA_WIDTH +: B2*DATA_WIDTH];

endmodule

// File: tb/tb_npu_param_loader.sv
// Randomised bench for npu_param_loader against a frame-level reference model.
// Honours NPU_PARAM_CHECKSUM_EN the same way as the design.
module tb_npu_param_loader;
   localparam int DW    = 8;
   localparam int W1    = 4;
   localparam int B1    = 2;
   localparam int W2    = 4;
   localparam int B2    = 2;
   localparam int TOTAL = W1 + B1 + W2 + B2;
   localparam int CW    = $clog2(TOTAL + 2);
`ifdef NPU_PARAM_CHECKSUM_EN
   localparam int FRAME = TOTAL + 1;
`else
   localparam int FRAME = TOTAL;
`endif

   logic                 clk, rst_n, load_start, s_valid, s_ready, s_last;
   logic [DW-1:0]        s_data;
   logic [W1*DW-1:0]     weights1;
   logic [B1*DW-1:0]     biases1;
   logic [W2*DW-1:0]     weights2;
   logic [B2*DW-1:0]     biases2;
   logic                 params_valid, busy, err;
   logic [1:0]           err_code;
   logic [CW-1:0]        word_cnt;

   npu_param_loader #(
      .IN_N       (2),
      .HIDDEN_N   (2),
      .OUT_N      (2),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .weights1     (weights1),
      .biases1      (biases1),
      .weights2     (weights2),
      .biases2      (biases2),
      .params_valid (params_valid),
      .busy         (busy),
      .err          (err),
      .err_code     (err_code),
      .word_cnt     (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: word memory plus frame status
   logic [DW-1:0] m_mem [TOTAL];
   int            m_cnt, m_code, m_sum;
   bit            m_busy, m_valid, m_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < TOTAL; k++) m_mem[k] = '0;
      m_cnt = 0; m_code = 0; m_sum = 0;
      m_busy = 0; m_valid = 0; m_err = 0;
   endtask

   task automatic model_accept(input logic [DW-1:0] d, input bit last);
      int k;
      k = m_cnt;
      m_cnt++;
      if (k < TOTAL) begin
         m_mem[k] = d;
         m_sum += int'(d);
      end
      if (last != (k == FRAME - 1)) begin
         m_busy = 0; m_err = 1; m_code = last ? 1 : 2;
      end else if (last) begin
         m_busy = 0;
         if (FRAME > TOTAL && d != DW'(m_sum)) begin
            m_err = 1; m_code = 3;
         end else begin
            m_valid = 1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [TOTAL*DW-1:0] flat;
      for (int k = 0; k < TOTAL; k++) flat[k*DW +: DW] = m_mem[k];
      chk({tag, ".weights1"}, 64'(weights1), 64'(flat[0 +: W1*DW]));
      chk({tag, ".biases1"},  64'(biases1),  64'(flat[W1*DW +: B1*DW]));
      chk({tag, ".weights2"}, 64'(weights2), 64'(flat[(W1+B1)*DW +: W2*DW]));
      chk({tag, ".biases2"},  64'(biases2),  64'(flat[(W1+B1+W2)*DW +: B2*DW]));
      chk({tag, ".s_ready"},  64'(s_ready),  64'(m_busy));
      chk({tag, ".busy"},     64'(busy),     64'(m_busy));
      chk({tag, ".params_valid"}, 64'(params_valid), 64'(m_valid));
      chk({tag, ".err"},      64'(err),      64'(m_err));
      chk({tag, ".err_code"}, 64'(err_code), 64'(m_code));
      chk({tag, ".word_cnt"}, 64'(word_cnt), 64'(m_cnt));
   endtask

   task automatic beat(input bit v, input logic [DW-1:0] d, input bit last, output bit acc);
      @(negedge clk);
      check_outputs("beat");
      load_start = 1'b0;
      s_valid    = v;
      s_data     = d;
      s_last     = last;
      acc        = v && m_busy;
      if (acc) model_accept(d, last);
   endtask

   task automatic idle_cycles(input int n);
      bit acc;
      for (int c = 0; c < n; c++) begin
         // s_valid noise is only driven while the model says nothing is loading
         beat(m_busy ? 1'b0 : 1'($urandom % 2), DW'($urandom), 1'($urandom % 2), acc);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      check_outputs("start");
      load_start = 1'b1;
      s_valid    = 1'($urandom % 2);
      s_data     = DW'($urandom);
      s_last     = 1'($urandom % 2);
      m_busy = 1; m_cnt = 0; m_valid = 0; m_err = 0; m_code = 0; m_sum = 0;
   endtask

   // kind: 0 good, 1 early s_last at early_pos, 2 missing s_last, 3 bad checksum
   // gap: 0 always valid, 1 toggle, 2 random
   task automatic send_frame(input int kind, input bit seq, input int gap, input int early_pos,
                             input int restart_at);
      logic [DW-1:0] w [FRAME];
      int n, lastpos, i, cyc, sum, rs;
      bit acc, v;
      sum = 0;
      rs  = restart_at;
      for (int k = 0; k < TOTAL; k++) begin
         w[k] = seq ? DW'(k + 1) : DW'($urandom);
         sum += int'(w[k]);
      end
`ifdef NPU_PARAM_CHECKSUM_EN
      w[TOTAL] = DW'(sum + ((kind == 3) ? 1 : 0));
`endif
      n = FRAME;
      lastpos = FRAME - 1;
      if (kind == 1) begin
         lastpos = early_pos;
         n = early_pos + 1;
      end else if (kind == 2) begin
         lastpos = -1;
      end
      if (rs >= n) rs = -1;
      start_load();
      i = 0;
      cyc = 0;
      while (i < n && cyc < 400) begin
         v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
         beat(v, w[i], i == lastpos, acc);
         cyc++;
         if (acc) i++;
         if (rs > 0 && i == rs) begin
            start_load();
            i  = 0;
            rs = -1;
         end
      end
      if (i < n) chk("frame_beats_sent", 64'(i), 64'(n));
      idle_cycles(2);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      check_outputs("pre_rst");
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      s_last  = 1'b0;
      #2;
      rst_n      = 1'b0;
      load_start = 1'b1;
      model_clear();
      @(negedge clk);
      check_outputs("in_rst");
      rst_n      = 1'b1;
      load_start = 1'b0;
      s_valid    = 1'b0;
   endtask

   task automatic check_seq_buses(input string tag);
      chk({tag, ".w1_const"}, 64'(weights1), 64'h0403_0201);
      chk({tag, ".b1_const"}, 64'(biases1),  64'h0605);
      chk({tag, ".w2_const"}, 64'(weights2), 64'h0A09_0807);
      chk({tag, ".b2_const"}, 64'(biases2),  64'h0C0B);
      chk({tag, ".pv_const"}, 64'(params_valid), 64'd1);
   endtask

   initial begin
      bit acc;
      rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      model_clear();
      @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
      idle_cycles(3);

      send_frame(0, 1'b1, 0, 0, -1);
      check_seq_buses("t1");

      send_frame(0, 1'b1, 1, 0, -1);
      check_seq_buses("t2");

      send_frame(1, 1'b1, 0, 4, -1);
      chk("t3.err_code", 64'(err_code), 64'd1);
      chk("t3.s_ready",  64'(s_ready),  64'd0);
      idle_cycles(3);

      send_frame(2, 1'b0, 2, 0, -1);
      chk("t4.err_code", 64'(err_code), 64'd2);
      send_frame(0, 1'b1, 0, 0, -1);
      chk("t4.err_cleared", 64'(err), 64'd0);
      check_seq_buses("t4");

      send_frame(0, 1'b1, 0, 0, 7);
      check_seq_buses("t5");

`ifdef NPU_PARAM_CHECKSUM_EN
      send_frame(0, 1'b1, 0, 0, -1);
      check_seq_buses("t6_good");
      send_frame(3, 1'b1, 0, 0, -1);
      chk("t6.err_code", 64'(err_code), 64'd3);
      chk("t6.pv",       64'(params_valid), 64'd0);
`endif

      start_load();
      for (int b = 0; b < 5; b++) beat(1'b1, DW'($urandom), 1'b0, acc);
      mid_reset();
      idle_cycles(2);

      for (int it = 0; it < 30; it++) begin
         send_frame(int'($urandom % 4), 1'b0, int'($urandom % 3),
                    int'($urandom_range(FRAME - 2, 0)),
                    ($urandom % 4 == 0) ? int'($urandom_range(10, 1)) : -1);
         idle_cycles(int'($urandom % 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
